// File: rtl/serial_com_mlane_pkg.sv
// Shared constants for the multi-lane frame serializer: FSM state codes,
// default frame patterns and a counter-width helper.
package serial_com_mlane_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_FILL = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_EOF  = 3'd5;

  localparam logic [31:0] DEF_SOF_PAT  = 32'h5a5a5a5a;
  localparam logic [31:0] DEF_EOF_PAT  = 32'h0f0f0f0f;
  localparam logic [31:0] DEF_FILL_PAT = 32'hc3c3c3c3;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_com_mlane_lane_sr.sv
// One serial lane: parallel load on a word boundary, otherwise shift right
// one bit per cycle; the LSB is the lane's serial output.
module serial_lane_sr #(
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] din,
  output logic          lsb
);

  logic [LW-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else begin
      sr <= sr >> 1;
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/serial_com_mlane.sv
// Frame serializer: pops FWFT FIFO words and emits SOF, DATA/FILL..., optional
// XOR checksum and EOF words, each word split across LANES LSB-first lanes.
module serial_com_mlane
  import serial_com_mlane_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                LANES    = 1,
  parameter logic [DATA_W-1:0] SOF_PAT  = DATA_W'(DEF_SOF_PAT),
  parameter logic [DATA_W-1:0] EOF_PAT  = DATA_W'(DEF_EOF_PAT),
  parameter logic [DATA_W-1:0] FILL_PAT = DATA_W'(DEF_FILL_PAT),
  parameter int                EOF_REPS = 2,
  parameter int                CHK_EN   = 1,
  parameter int                UFC_W    = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [DATA_W:0]   rdata,
  input  logic              rempty,
  output logic              r_en,
  output logic [LANES-1:0]  s_out,
  output logic              s_frame,
  output logic [UFC_W-1:0]  underflow_cnt
);

  localparam int LW = DATA_W / LANES;
  localparam int CW = cnt_width(LW);
  localparam int RW = cnt_width(EOF_REPS + 1);

  logic [2:0]        state, next_state;
  logic [CW-1:0]     bit_cnt;
  logic              boundary;
  logic [RW-1:0]     rep;
  logic [DATA_W-1:0] chk, next_word;
  logic              last_flag, take, fill;

  assign boundary = (bit_cnt == CW'(LW - 1));

  // Next state and the word loaded into the lanes at the coming boundary.
  always_comb begin
    next_state = state;
    next_word  = '0;
    take       = 1'b0;
    fill       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rempty) begin
          next_state = ST_SOF;
          next_word  = SOF_PAT;
        end
      end
      ST_SOF, ST_FILL, ST_DATA: begin
        if (state == ST_DATA && last_flag) begin
          if (CHK_EN != 0) begin
            next_state = ST_CHK;
            next_word  = chk;
          end else begin
            next_state = ST_EOF;
            next_word  = EOF_PAT;
          end
        end else if (!rempty) begin
          next_state = ST_DATA;
          next_word  = rdata[DATA_W-1:0];
          take       = 1'b1;
        end else begin
          next_state = ST_FILL;
          next_word  = FILL_PAT;
          fill       = 1'b1;
        end
      end
      ST_CHK: begin
        next_state = ST_EOF;
        next_word  = EOF_PAT;
      end
      ST_EOF: begin
        if (rep < RW'(EOF_REPS)) begin
          next_state = ST_EOF;
          next_word  = EOF_PAT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Popping during reset would silently lose a word, so the strobe is gated.
  assign r_en    = boundary && take && !rrst;
  assign s_frame = (state != ST_IDLE);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      rep           <= '0;
      chk           <= '0;
      last_flag     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      bit_cnt <= boundary ? '0 : bit_cnt + CW'(1);
      if (boundary) begin
        state <= next_state;
        if (take) begin
          chk       <= chk ^ rdata[DATA_W-1:0];
          last_flag <= rdata[DATA_W];
        end
        if (next_state == ST_SOF || state == ST_CHK) begin
          chk <= '0;
        end
        if (next_state == ST_EOF) begin
          rep <= (state == ST_EOF) ? rep + RW'(1) : RW'(1);
        end
        if (fill && underflow_cnt != '1) begin
          underflow_cnt <= underflow_cnt + UFC_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serial_lane_sr #(.LW(LW)) u_sr (
      .clk  (rclk),
      .rst  (rrst),
      .load (boundary),
      .din  (next_word[i*LW +: LW]),
      .lsb  (s_out[i])
    );
  end

endmodule

// File: tb/tb_serial_com_mlane.sv
// Bench for serial_com_mlane: a default single-lane instance and a 4-lane,
// no-checksum, single-EOF instance, each fed by a queue FIFO and a frame parser.
module tb_serial_com_mlane;

  localparam logic [31:0] SOF  = 32'h5a5a5a5a;
  localparam logic [31:0] EOF  = 32'h0f0f0f0f;
  localparam logic [31:0] FILL = 32'hc3c3c3c3;
  localparam int P_IDLE = 0, P_BODY = 1, P_CHK = 2, P_EOF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rrst0, rrst1, rempty0, rempty1, r_en0, r_en1, frame0, frame1;
  logic [32:0] rdata0, rdata1;
  logic [0:0]  sout0;
  logic [3:0]  sout1;
  logic [15:0] ucnt0, ucnt1;

  serial_com_mlane dut0 (
    .rclk(clk), .rrst(rrst0), .rdata(rdata0), .rempty(rempty0), .r_en(r_en0),
    .s_out(sout0), .s_frame(frame0), .underflow_cnt(ucnt0)
  );

  serial_com_mlane #(.LANES(4), .CHK_EN(0), .EOF_REPS(1)) dut1 (
    .rclk(clk), .rrst(rrst1), .rdata(rdata1), .rempty(rempty1), .r_en(r_en1),
    .s_out(sout1), .s_frame(frame1), .underflow_cnt(ucnt1)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] fq0[$], fq1[$], eq0[$], eq1[$];
  logic [31:0] wlog0[$], wlog1[$], exp_log[$];
  logic        gate[2];
  logic        gap_ok[2];
  logic [31:0] xacc[2];
  int pops[2], pushes[2], pst[2], eof_left[2], fills[2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] d, input logic last);
    if (u == 0) begin
      fq0.push_back({last, d});
      eq0.push_back({last, d});
    end else begin
      fq1.push_back({last, d});
      eq1.push_back({last, d});
    end
    pushes[u]++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitPops(input int u, input int target);
    int n = 0;
    while (pops[u] < target && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    checkOutput($sformatf("dut%0d_wait_pops", u), pops[u] >= target, 1);
  endtask

  function automatic void resetParser(input int u);
    pst[u] = P_IDLE;
    gap_ok[u] = 1'b1;
    fills[u] = 0;
    xacc[u] = '0;
    if (u == 0) eq0.delete(); else eq1.delete();
  endfunction

  // Frame grammar: zeros, SOF, (DATA|FILL)*, [CHK], EOF x reps, then >=1 zero word.
  task automatic consumeWord(input int u, input logic [31:0] w);
    logic [32:0] e;
    logic have;
    case (pst[u])
      P_IDLE: begin
        if (w == 0) gap_ok[u] = 1'b1;
        else begin
          checkOutput($sformatf("dut%0d_sof", u), w, SOF);
          checkOutput($sformatf("dut%0d_gap", u), gap_ok[u], 1);
          pst[u] = P_BODY;
          xacc[u] = '0;
        end
      end
      P_BODY: begin
        if (w == FILL) fills[u]++;
        else begin
          e = '0;
          if (u == 0) begin
            have = eq0.size() != 0;
            if (have) e = eq0.pop_front();
          end else begin
            have = eq1.size() != 0;
            if (have) e = eq1.pop_front();
          end
          checkOutput($sformatf("dut%0d_data_pending", u), have, 1);
          if (have) begin
            checkOutput($sformatf("dut%0d_data", u), w, e[31:0]);
            xacc[u] ^= e[31:0];
            if (e[32]) begin
              pst[u] = (u == 0) ? P_CHK : P_EOF;
              eof_left[u] = (u == 0) ? 2 : 1;
            end
          end
        end
      end
      P_CHK: begin
        checkOutput($sformatf("dut%0d_chk", u), w, xacc[u]);
        pst[u] = P_EOF;
      end
      default: begin
        checkOutput($sformatf("dut%0d_eof", u), w, EOF);
        eof_left[u]--;
        if (eof_left[u] == 0) begin
          pst[u] = P_IDLE;
          gap_ok[u] = 1'b0;
        end
      end
    endcase
  endtask

  task automatic checkLog(input int u, input string tag);
    logic [31:0] lg[$];
    int idx = 0;
    if (u == 0) lg = wlog0; else lg = wlog1;
    while (idx < lg.size() && lg[idx] == 0) idx++;
    checkOutput({tag, "_len"}, lg.size() >= idx + exp_log.size(), 1);
    foreach (exp_log[k])
      if (idx + k < lg.size())
        checkOutput($sformatf("%s_w%0d", tag, k), lg[idx + k], exp_log[k]);
  endtask

  // FIFO models: pop on a sampled r_en, then present the new head.
  initial begin : fifo_0
    logic pend;
    rempty0 = 1'b1;
    rdata0 = '0;
    forever begin
      @(negedge clk);
      pend = r_en0;
      if (r_en0) checkOutput("dut0_ren_not_empty", rempty0, 0);
      @(posedge clk);
      #1;
      if (pend && fq0.size() > 0) begin
        void'(fq0.pop_front());
        pops[0]++;
      end
      #1;
      rempty0 = gate[0] || (fq0.size() == 0);
      rdata0 = (fq0.size() > 0) ? fq0[0] : '0;
    end
  end

  initial begin : fifo_1
    logic pend;
    rempty1 = 1'b1;
    rdata1 = '0;
    forever begin
      @(negedge clk);
      pend = r_en1;
      if (r_en1) checkOutput("dut1_ren_not_empty", rempty1, 0);
      @(posedge clk);
      #1;
      if (pend && fq1.size() > 0) begin
        void'(fq1.pop_front());
        pops[1]++;
      end
      #1;
      rempty1 = gate[1] || (fq1.size() == 0);
      rdata1 = (fq1.size() > 0) ? fq1[0] : '0;
    end
  end

  // Monitors rebuild words from the lanes; word phase restarts on reset.
  initial begin : mon_0
    int ph;
    logic [31:0] acc;
    ph = 0;
    acc = '0;
    forever begin
      @(posedge clk);
      if (rrst0) begin
        ph = 0;
        acc = '0;
        resetParser(0);
      end else ph = (ph + 1) % 32;
      @(negedge clk);
      acc[ph] = sout0[0];
      if (ph == 31) begin
        wlog0.push_back(acc);
        consumeWord(0, acc);
      end
    end
  end

  initial begin : mon_1
    int ph;
    logic [31:0] acc;
    ph = 0;
    acc = '0;
    forever begin
      @(posedge clk);
      if (rrst1) begin
        ph = 0;
        acc = '0;
        resetParser(1);
      end else ph = (ph + 1) % 8;
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i*8 + ph] = sout1[i];
      if (ph == 7) begin
        wlog1.push_back(acc);
        consumeWord(1, acc);
      end
    end
  end

  task automatic randomRun(input int u);
    int lw = (u == 0) ? 32 : 8;
    int n = 0;
    int len;
    logic [31:0] d;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        d = $urandom;
        if (d == FILL) d = ~d;
        applyStimulus(u, d, k == len - 1);
        cycles($urandom_range(0, 3 * lw));
        gate[u] = ($urandom_range(0, 2) == 0);
      end
    end
    gate[u] = 1'b0;
    while (!(((u == 0) ? fq0.size() : fq1.size()) == 0 && pst[u] == P_IDLE) && n < 20000) begin
      cycles(1);
      n++;
    end
    checkOutput($sformatf("dut%0d_drain", u), n < 20000, 1);
    cycles(3 * lw);
    checkOutput($sformatf("dut%0d_ucnt", u), (u == 0) ? ucnt0 : ucnt1, fills[u]);
    checkOutput($sformatf("dut%0d_pops", u), pops[u], pushes[u]);
    checkOutput($sformatf("dut%0d_left", u), (u == 0) ? eq0.size() : eq1.size(), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int p;
    gate[0] = 1'b0;
    gate[1] = 1'b0;
    rrst0 = 1'b1;
    rrst1 = 1'b1;
    cycles(3);
    checkOutput("rst_sout0", sout0, 0);
    checkOutput("rst_ren0", r_en0, 0);
    checkOutput("rst_frame0", frame0, 0);
    checkOutput("rst_ucnt0", ucnt0, 0);
    checkOutput("rst_sout1", sout1, 0);
    checkOutput("rst_frame1", frame1, 0);
    rrst0 = 1'b0;
    rrst1 = 1'b0;
    cycles(64);

    wlog0.delete();
    p = pops[0];
    applyStimulus(0, 32'h11111111, 1'b0);
    applyStimulus(0, 32'h22222222, 1'b0);
    applyStimulus(0, 32'h33333333, 1'b1);
    cycles(48);
    checkOutput("t1_frame", frame0, 1);
    cycles(320);
    checkOutput("t1_pops", pops[0] - p, 3);
    checkOutput("t1_frame_idle", frame0, 0);
    exp_log = '{SOF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0, EOF, EOF, 32'h0};
    checkLog(0, "t1");

    wlog1.delete();
    p = pops[1];
    applyStimulus(1, 32'h76543210, 1'b1);
    cycles(64);
    checkOutput("t2_pops", pops[1] - p, 1);
    exp_log = '{SOF, 32'h76543210, EOF, 32'h0};
    checkLog(1, "t2");

    wlog0.delete();
    p = pops[0];
    applyStimulus(0, 32'h12345678, 1'b0);
    waitPops(0, p + 1);
    cycles(2 * 32 + 16);
    applyStimulus(0, 32'h9abcdef0, 1'b0);
    applyStimulus(0, 32'h0f1e2d3c, 1'b1);
    cycles(320);
    checkOutput("t3_ucnt", ucnt0, 2);
    exp_log = '{SOF, 32'h12345678, FILL, FILL, 32'h9abcdef0, 32'h0f1e2d3c,
                32'h12345678 ^ 32'h9abcdef0 ^ 32'h0f1e2d3c, EOF, EOF, 32'h0};
    checkLog(0, "t3");

    wlog0.delete();
    applyStimulus(0, 32'ha0a0a0a1, 1'b0);
    applyStimulus(0, 32'h0000beef, 1'b1);
    applyStimulus(0, 32'h600dcafe, 1'b1);
    cycles(512);
    exp_log = '{SOF, 32'ha0a0a0a1, 32'h0000beef, 32'ha0a0a0a1 ^ 32'h0000beef, EOF, EOF, 32'h0,
                SOF, 32'h600dcafe, 32'h600dcafe, EOF, EOF, 32'h0};
    checkLog(0, "t4");

    p = pops[0];
    applyStimulus(0, 32'h01010101, 1'b0);
    applyStimulus(0, 32'h02020202, 1'b0);
    applyStimulus(0, 32'h03030303, 1'b0);
    applyStimulus(0, 32'h04040404, 1'b1);
    waitPops(0, p + 2);
    cycles(5);
    checkOutput("t5_ucnt_before", ucnt0, 2);
    checkOutput("t5_frame_before", frame0, 1);
    rrst0 = 1'b1;
    @(posedge clk);
    #1;
    rrst0 = 1'b0;
    #1;
    checkOutput("t5_sout", sout0, 0);
    checkOutput("t5_ren", r_en0, 0);
    checkOutput("t5_frame", frame0, 0);
    checkOutput("t5_ucnt", ucnt0, 0);
    fq0.delete();
    pushes[0] = pops[0];
    wlog0.delete();
    applyStimulus(0, 32'h5eed0001, 1'b1);
    cycles(320);
    exp_log = '{SOF, 32'h5eed0001, 32'h5eed0001, EOF, EOF, 32'h0};
    checkLog(0, "t5");
    checkOutput("t5_ucnt_after", ucnt0, 0);

    randomRun(0);
    randomRun(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
